// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: collects CHANNELS slot words per frame into a
// shadow buffer and publishes them as one parallel word with a one-cycle strobe.
module tdm_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int ERRW     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_sof,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  output logic                      frame_err,
  output logic [ERRW-1:0]           err_count
);

  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [SW-1:0]   LAST_SLOT = SW'(CHANNELS - 1);
  localparam logic [ERRW-1:0] ERR_MAX   = {ERRW{1'b1}};

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [SW-1:0]             slot_q, slot_d;
  logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
  logic [CHANNELS*WIDTH-1:0] out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      frame_err_q, frame_err_d;
  logic [ERRW-1:0]           err_count_q, err_count_d;

  // Register all state and outputs; synchronous reset drops any partial frame silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      slot_q      <= {SW{1'b0}};
      shadow_q    <= {(CHANNELS*WIDTH){1'b0}};
      out_data_q  <= {(CHANNELS*WIDTH){1'b0}};
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_count_q <= {ERRW{1'b0}};
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state, slot capture and publication logic.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    shadow_d    = shadow_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;
    err_count_d = err_count_q;

    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_sof) begin
            shadow_d[WIDTH-1:0] = in_data;
            slot_d              = SW'(1);
            state_d             = COLLECT;
          end else begin
            state_d = HUNT;
          end
        end
        COLLECT: begin
          if (in_sof) begin
            // Early sof: count the truncated frame and restart on this word as slot 0.
            frame_err_d = 1'b1;
            if (err_count_q != ERR_MAX) begin
              err_count_d = err_count_q + {{(ERRW-1){1'b0}}, 1'b1};
            end else begin
              err_count_d = err_count_q;
            end
            shadow_d[WIDTH-1:0] = in_data;
            slot_d              = SW'(1);
            state_d             = COLLECT;
          end else begin
            shadow_d[32'(slot_q) * WIDTH +: WIDTH] = in_data;
            if (slot_q == LAST_SLOT) begin
              out_data_d  = shadow_d;
              out_valid_d = 1'b1;
              slot_d      = {SW{1'b0}};
              state_d     = HUNT;
            end else begin
              slot_d = slot_q + SW'(1);
            end
          end
        end
        default: begin
          state_d = HUNT;
          slot_d  = {SW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux: a default instance (ERRW=8) and a
// narrow-counter instance (ERRW=2) share one input stream.
module tb_tdm_demux;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;

  logic                      clk;
  logic                      rst;
  logic                      in_valid;
  logic [WIDTH-1:0]          in_data;
  logic                      in_sof;
  logic [CHANNELS*WIDTH-1:0] out_data, out_data2;
  logic                      out_valid, out_valid2;
  logic                      frame_err, frame_err2;
  logic [7:0]                err_count;
  logic [1:0]                err_count2;

  int checks;
  int errors;
  int pulses;

  tdm_demux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .ERRW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .out_data(out_data), .out_valid(out_valid), .frame_err(frame_err), .err_count(err_count)
  );

  tdm_demux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .ERRW(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .out_data(out_data2), .out_valid(out_valid2), .frame_err(frame_err2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) pulses++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic v, input logic s, input logic [7:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int p0;
    checks = 0;
    errors = 0;
    pulses = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_data = 8'h00;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'($urandom_range(1));
      in_sof   = 1'($urandom_range(1));
      in_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_frame_err", 64'(frame_err), 64'h0);
    chk("rst_err_count", 64'(err_count), 64'h0);
    chk("rst_err_count2", 64'(err_count2), 64'h0);

    // Clean frame
    beat(1'b1, 1'b1, 8'h11);
    chk("clean_no_valid_s0", 64'(out_valid), 64'h0);
    beat(1'b1, 1'b0, 8'h22);
    beat(1'b1, 1'b0, 8'h33);
    chk("clean_no_valid_s2", 64'(out_valid), 64'h0);
    beat(1'b1, 1'b0, 8'h44);
    chk("clean_valid", 64'(out_valid), 64'h1);
    chk("clean_data", 64'(out_data), 64'h44332211);
    chk("clean_no_err", 64'(frame_err), 64'h0);

    // Back-to-back frame, pulse exactly 4 cycles later
    beat(1'b1, 1'b1, 8'hA1);
    chk("b2b_pulse_ends", 64'(out_valid), 64'h0);
    chk("b2b_data_hold", 64'(out_data), 64'h44332211);
    beat(1'b1, 1'b0, 8'hA2);
    beat(1'b1, 1'b0, 8'hA3);
    chk("b2b_no_valid_s2", 64'(out_valid), 64'h0);
    beat(1'b1, 1'b0, 8'hA4);
    chk("b2b_valid", 64'(out_valid), 64'h1);
    chk("b2b_data", 64'(out_data), 64'hA4A3A2A1);
    chk("b2b_data2", 64'(out_data2), 64'hA4A3A2A1);

    // Junk without sof, then a gapped frame
    beat(1'b1, 1'b0, 8'h55);
    p0 = pulses;
    beat(1'b1, 1'b0, 8'h66);
    chk("junk_no_valid", 64'(out_valid), 64'h0);
    chk("junk_no_err", 64'(frame_err), 64'h0);
    beat(1'b1, 1'b1, 8'h01);
    idle(3);
    beat(1'b1, 1'b0, 8'h02);
    idle(3);
    chk("gap_no_valid", 64'(out_valid), 64'h0);
    beat(1'b1, 1'b0, 8'h03);
    idle(3);
    chk("gap_data_hold", 64'(out_data), 64'hA4A3A2A1);
    beat(1'b1, 1'b0, 8'h04);
    chk("gap_valid", 64'(out_valid), 64'h1);
    chk("gap_data", 64'(out_data), 64'h04030201);
    idle(1);
    chk("gap_valid_drop", 64'(out_valid), 64'h0);
    chk("gap_single_pulse", 64'(pulses - p0), 64'h1);

    // Early sof
    beat(1'b1, 1'b1, 8'h11);
    beat(1'b1, 1'b0, 8'h22);
    beat(1'b1, 1'b1, 8'h77);
    chk("early_err", 64'(frame_err), 64'h1);
    chk("early_count", 64'(err_count), 64'h1);
    chk("early_no_valid", 64'(out_valid), 64'h0);
    chk("early_data_hold", 64'(out_data), 64'h04030201);
    beat(1'b1, 1'b0, 8'h88);
    chk("early_err_drop", 64'(frame_err), 64'h0);
    beat(1'b1, 1'b0, 8'h99);
    beat(1'b1, 1'b0, 8'hAA);
    chk("early_valid", 64'(out_valid), 64'h1);
    chk("early_data", 64'(out_data), 64'hAA998877);
    chk("early_err_no_overlap", 64'(frame_err), 64'h0);
    chk("early_count_keep", 64'(err_count), 64'h1);

    // Five more early sofs: narrow counter saturates at 3
    beat(1'b1, 1'b1, 8'hE0);
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, 1'b0, 8'(8'hD0 + i));
      beat(1'b1, 1'b1, 8'(8'hE0 + i));
      chk("sat_err_pulse", 64'(frame_err2), 64'h1);
      chk("sat_count2", 64'(err_count2), (i < 2) ? 64'(i + 2) : 64'h3);
      chk("sat_count8", 64'(err_count), 64'(i + 2));
    end
    beat(1'b1, 1'b0, 8'hF1);
    beat(1'b1, 1'b0, 8'hF2);
    beat(1'b1, 1'b0, 8'hF3);
    chk("sat_frame_valid", 64'(out_valid), 64'h1);
    chk("sat_frame_data", 64'(out_data), 64'hF3F2F1E4);

    // Reset mid-frame drops the partial frame silently
    beat(1'b1, 1'b1, 8'h11);
    beat(1'b1, 1'b0, 8'h22);
    rst = 1'b1;
    beat(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    chk("mid_rst_data", 64'(out_data), 64'h0);
    chk("mid_rst_count", 64'(err_count), 64'h0);
    chk("mid_rst_count2", 64'(err_count2), 64'h0);
    beat(1'b1, 1'b0, 8'h33);
    chk("mid_rst_no_valid_a", 64'(out_valid), 64'h0);
    beat(1'b1, 1'b0, 8'h44);
    chk("mid_rst_no_valid_b", 64'(out_valid), 64'h0);
    chk("mid_rst_no_err", 64'(frame_err), 64'h0);
    idle(1);
    chk("mid_rst_data_hold", 64'(out_data), 64'h0);
    chk("mid_rst_no_valid_c", 64'(out_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive-side counterpart of the team's mux datapath: takes a time-division-multiplexed word stream and routes each slot back to its own lane.
- A frame is CHANNELS consecutive accepted words, with slot 0 marked by in_sof.
- Lanes are collected in a shadow buffer and published atomically as one parallel word with a one-cycle valid strobe.
- Sits downstream of the TDM mux/serializer on the same link.

Parameters:
- WIDTH, 8, bits per slot/lane word.
- CHANNELS, 4, slots per frame (legal range 2..16).
- ERRW, 8, width of saturating frame-error counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_sof qualify this cycle; no backpressure, always accepted.
- in_data  input  WIDTH  slot word.
- in_sof  input  1  start of frame; word is slot 0; ignored when in_valid=0.
- out_data  output  CHANNELS*WIDTH  last complete frame; lane k at bits [k*WIDTH +: WIDTH].
- out_valid  output  1  one-cycle pulse when out_data updated.
- frame_err  output  1  one-cycle pulse on a truncated frame.
- err_count  output  ERRW  saturating count of frame_err events.

Behaviour:
- Reset (rst=1 at edge): state=HUNT, slot=0, shadow=0, out_data=0, out_valid=0, frame_err=0, err_count=0. Reset overrides any in-flight frame; a partial frame is dropped silently with no frame_err.
- States: HUNT (waiting for sof) and COLLECT (slots 1..CHANNELS-1 pending).
- HUNT:
  - in_valid & in_sof: shadow lane0 <= in_data, slot <= 1, go to COLLECT.
  - in_valid & !in_sof: word discarded, no error, stay in HUNT.
- COLLECT, in_valid & !in_sof:
  - shadow[slot] <= in_data.
  - If slot == CHANNELS-1: out_data <= shadow with this word in lane CHANNELS-1 (all lanes in the same edge), out_valid=1 next cycle, slot <= 0, go to HUNT.
  - Otherwise slot <= slot+1.
- COLLECT, in_valid & in_sof (early sof):
  - frame_err=1 next cycle; err_count += 1, saturating at 2^ERRW-1.
  - Partial frame is discarded; out_data is not updated.
  - Restart: shadow lane0 <= in_data, slot <= 1, stay in COLLECT.
- in_valid=0: no state, slot or shadow change. Gaps are allowed anywhere in a frame with no timeout.
- Latency: out_valid asserts exactly 1 cycle after the edge that accepts the last slot. out_data is valid the same cycle and holds until the next completed frame.
- Back-to-back frames: an sof in the cycle right after the last slot is accepted in HUNT with no bubble. Sustained rate is one frame per CHANNELS cycles.
- Shadow lanes are not cleared between frames. Every lane is overwritten before publication, so stale data never reaches out_data.
- out_valid and frame_err are registered, deasserted by default, and never asserted together.
- Slot counter is $clog2(CHANNELS) bits wide. It never wraps past CHANNELS-1.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> out_data=0, out_valid=0, frame_err=0, err_count=0.
- Clean frame: WIDTH=8, CHANNELS=4; beats 0x11(sof), 0x22, 0x33, 0x44 on consecutive cycles -> out_valid pulses 1 cycle after the 0x44 beat, out_data=0x44332211; then back-to-back frame 0xA1(sof), 0xA2, 0xA3, 0xA4 -> second pulse exactly 4 cycles later, out_data=0xA4A3A2A1.
- Gaps and junk: 0x55, 0x66 without sof, then a frame 0x01(sof), 0x02, 0x03, 0x04 with in_valid low 3 cycles between beats -> junk dropped, out_data=0x04030201, a single out_valid pulse.
- Early sof: 0x11(sof), 0x22, then 0x77(sof), 0x88, 0x99, 0xAA -> frame_err pulse 1 cycle after the 0x77 beat, err_count=1, then out_valid with out_data=0xAA998877.
- Saturation: ERRW=2; force 5 early-sof events -> frame_err pulses 5 times, err_count stops at 3.
- Reset mid-frame: 0x11(sof), 0x22, rst pulse, then 0x33, 0x44 (no sof) -> no out_valid, out_data stays 0, no frame_err.
